// File: rtl/shift_register_stepper.sv
// Multi-mode WIDTH-bit register (hold/load/shift/rotate/clear) advanced either by an
// internal prescaler tick or by a synchronised, edge-detected push-button step.
module shift_register_stepper #(
   parameter int WIDTH  = 8,
   parameter int DIVIDE = 50_000_000
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             enable,
   input  logic             auto,
   input  logic             step,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             serial_in,
   output logic [WIDTH-1:0] q,
   output logic             serial_out,
   output logic             tick
);

   localparam int CW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIVIDE - 1);

   localparam logic [2:0] OP_HOLD  = 3'b000;
   localparam logic [2:0] OP_LOAD  = 3'b001;
   localparam logic [2:0] OP_SHL   = 3'b010;
   localparam logic [2:0] OP_SHR   = 3'b011;
   localparam logic [2:0] OP_ROTL  = 3'b100;
   localparam logic [2:0] OP_ROTR  = 3'b101;
   localparam logic [2:0] OP_CLEAR = 3'b110;

   logic             sync1_q, sync2_q, hist_q;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] reg_q, reg_d;
   logic             sout_q, sout_d;
   logic             tick_q;
   logic             step_pulse, pre_tick, advance;

   assign step_pulse = sync2_q & ~hist_q;
   assign pre_tick   = auto & (cnt_q == CNT_LAST);
   assign advance    = enable & (auto ? pre_tick : step_pulse);

   // Prescaler free-runs regardless of enable so re-enabling waits for the next wrap.
   always_comb begin
      cnt_d = '0;
      if (auto) begin
         cnt_d = pre_tick ? '0 : cnt_q + CW'(1);
      end
   end

   always_comb begin
      reg_d  = reg_q;
      sout_d = sout_q;
      if (advance) begin
         case (mode)
            OP_LOAD:  reg_d = d;
            OP_SHL: begin
               reg_d  = {reg_q[WIDTH-2:0], serial_in};
               sout_d = reg_q[WIDTH-1];
            end
            OP_SHR: begin
               reg_d  = {serial_in, reg_q[WIDTH-1:1]};
               sout_d = reg_q[0];
            end
            OP_ROTL: begin
               reg_d  = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
               sout_d = reg_q[WIDTH-1];
            end
            OP_ROTR: begin
               reg_d  = {reg_q[0], reg_q[WIDTH-1:1]};
               sout_d = reg_q[0];
            end
            OP_CLEAR: reg_d = '0;
            OP_HOLD:  reg_d = reg_q;
            default:  reg_d = reg_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= 1'b0;
         cnt_q   <= '0;
         reg_q   <= '0;
         sout_q  <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         sync1_q <= step;
         sync2_q <= sync1_q;
         hist_q  <= sync2_q;
         cnt_q   <= cnt_d;
         reg_q   <= reg_d;
         sout_q  <= sout_d;
         tick_q  <= advance;
      end
   end

   assign q          = reg_q;
   assign serial_out = sout_q;
   assign tick       = tick_q;

endmodule

// File: tb/tb_shift_register_stepper.sv
// Directed bench for shift_register_stepper with WIDTH=8, DIVIDE=4.
module tb_shift_register_stepper;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic       auto = 1'b0;
   logic       step = 1'b0;
   logic [2:0] mode = 3'b000;
   logic [7:0] d = 8'h00;
   logic       serial_in = 1'b0;
   logic [7:0] q;
   logic       serial_out;
   logic       tick;

   int errors = 0;
   int checks = 0;

   shift_register_stepper #(.WIDTH(8), .DIVIDE(4)) dut (
      .clock(clock), .reset_n(reset_n), .enable(enable), .auto(auto), .step(step),
      .mode(mode), .d(d), .serial_in(serial_in), .q(q), .serial_out(serial_out), .tick(tick)
   );

   always #5 clock = ~clock;

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Returns the number of edges until tick is seen (capped at 20).
   task automatic wait_tick(output int n);
      n = 0;
      do begin
         cyc(1);
         n++;
      end while (!tick && n < 20);
   endtask

   task automatic do_reset(input logic a, input logic e, input logic [2:0] m,
                           input logic [7:0] dd, input logic si);
      auto = a; enable = e; mode = m; d = dd; serial_in = si; step = 1'b0;
      reset_n = 1'b0;
      cyc(2);
      reset_n = 1'b1;
   endtask

   task automatic press(input logic [2:0] m);
      mode = m;
      step = 1'b1;
      cyc(3);
      step = 1'b0;
      cyc(3);
   endtask

   task automatic test_reset();
      auto = 1'($urandom); enable = 1'($urandom); step = 1'($urandom);
      mode = 3'($urandom); d = 8'($urandom); serial_in = 1'($urandom);
      reset_n = 1'b0;
      cyc(3);
      checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h want 00", q); end
      checks++; if (serial_out !== 1'b0) begin errors++; $display("FAIL reset_sout: got %b want 0", serial_out); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
      auto = 1'b1; enable = 1'b1; mode = 3'b001; d = 8'h3C; step = 1'b0;
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_early_tick: edge %0d got %b want 0", i, tick); end
      end
      cyc(1);
      checks++; if (tick !== 1'b1) begin errors++; $display("FAIL reset_first_tick: got %b want 1", tick); end
      checks++; if (q !== 8'h3C) begin errors++; $display("FAIL reset_first_load: got %h want 3c", q); end
   endtask

   task automatic test_auto_load_shift();
      int n;
      do_reset(1'b1, 1'b1, 3'b001, 8'hA5, 1'b1);
      wait_tick(n);
      checks++; if (n != 4) begin errors++; $display("FAIL auto_first_lat: got %0d want 4", n); end
      checks++; if (q !== 8'hA5) begin errors++; $display("FAIL auto_load: got %h want a5", q); end
      mode = 3'b010; d = 8'h00;
      cyc(1);
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL auto_tick_width: got %b want 0", tick); end
      wait_tick(n);
      checks++; if (n != 3) begin errors++; $display("FAIL auto_period1: got %0d want 3", n); end
      checks++; if (q !== 8'h4B) begin errors++; $display("FAIL auto_shl1: got %h want 4b", q); end
      checks++; if (serial_out !== 1'b1) begin errors++; $display("FAIL auto_sout1: got %b want 1", serial_out); end
      wait_tick(n);
      checks++; if (n != 4) begin errors++; $display("FAIL auto_period2: got %0d want 4", n); end
      checks++; if (q !== 8'h97) begin errors++; $display("FAIL auto_shl2: got %h want 97", q); end
      checks++; if (serial_out !== 1'b0) begin errors++; $display("FAIL auto_sout2: got %b want 0", serial_out); end
   endtask

   task automatic test_manual_step();
      int ticks;
      do_reset(1'b0, 1'b1, 3'b001, 8'h80, 1'b0);
      cyc(2);
      step = 1'b1;
      cyc(1);
      checks++; if (q !== 8'h00 || tick !== 1'b0) begin errors++; $display("FAIL step_lat_n: got q=%h tick=%b want 00/0", q, tick); end
      cyc(1);
      checks++; if (q !== 8'h00 || tick !== 1'b0) begin errors++; $display("FAIL step_lat_n1: got q=%h tick=%b want 00/0", q, tick); end
      cyc(1);
      checks++; if (q !== 8'h80 || tick !== 1'b1) begin errors++; $display("FAIL step_lat_n2: got q=%h tick=%b want 80/1", q, tick); end
      step = 1'b0;
      cyc(3);
      mode = 3'b011; serial_in = 1'b0; d = 8'hFF;
      step = 1'b1;
      ticks = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (tick) ticks++;
      end
      checks++; if (ticks != 1) begin errors++; $display("FAIL step_long_press_ticks: got %0d want 1", ticks); end
      checks++; if (q !== 8'h40) begin errors++; $display("FAIL step_long_press_q: got %h want 40", q); end
      step = 1'b0;
      cyc(3);
      step = 1'b1;
      cyc(3);
      checks++; if (q !== 8'h20) begin errors++; $display("FAIL step_second_press: got %h want 20", q); end
      step = 1'b0;
      cyc(3);
   endtask

   task automatic test_rotate();
      do_reset(1'b0, 1'b1, 3'b001, 8'h81, 1'b0);
      press(3'b001);
      checks++; if (q !== 8'h81) begin errors++; $display("FAIL rot_load: got %h want 81", q); end
      press(3'b100);
      checks++; if (q !== 8'h03 || serial_out !== 1'b1) begin errors++; $display("FAIL rotl: got q=%h so=%b want 03/1", q, serial_out); end
      press(3'b101);
      checks++; if (q !== 8'h81 || serial_out !== 1'b1) begin errors++; $display("FAIL rotr1: got q=%h so=%b want 81/1", q, serial_out); end
      press(3'b101);
      checks++; if (q !== 8'hC0 || serial_out !== 1'b1) begin errors++; $display("FAIL rotr2: got q=%h so=%b want c0/1", q, serial_out); end
      serial_in = 1'b0;
      press(3'b011);
      checks++; if (q !== 8'h60 || serial_out !== 1'b0) begin errors++; $display("FAIL shr_after_rot: got q=%h so=%b want 60/0", q, serial_out); end
   endtask

   task automatic test_enable_reserved();
      int n;
      int ticks;
      do_reset(1'b1, 1'b1, 3'b001, 8'h5A, 1'b0);
      wait_tick(n);
      checks++; if (q !== 8'h5A) begin errors++; $display("FAIL en_load: got %h want 5a", q); end
      enable = 1'b0; mode = 3'b110;
      ticks = 0;
      for (int i = 0; i < 12; i++) begin
         cyc(1);
         if (tick) ticks++;
      end
      checks++; if (ticks != 0) begin errors++; $display("FAIL en_off_ticks: got %0d want 0", ticks); end
      checks++; if (q !== 8'h5A) begin errors++; $display("FAIL en_off_q: got %h want 5a", q); end
      cyc(2);
      enable = 1'b1;
      cyc(1);
      checks++; if (q !== 8'h5A || tick !== 1'b0) begin errors++; $display("FAIL en_mid_count: got q=%h tick=%b want 5a/0", q, tick); end
      cyc(1);
      checks++; if (q !== 8'h00 || tick !== 1'b1) begin errors++; $display("FAIL en_next_wrap: got q=%h tick=%b want 00/1", q, tick); end
      mode = 3'b001; d = 8'hC3;
      wait_tick(n);
      checks++; if (q !== 8'hC3) begin errors++; $display("FAIL res_load: got %h want c3", q); end
      mode = 3'b010; serial_in = 1'b0;
      wait_tick(n);
      checks++; if (q !== 8'h86 || serial_out !== 1'b1) begin errors++; $display("FAIL res_shl: got q=%h so=%b want 86/1", q, serial_out); end
      mode = 3'b111; serial_in = 1'b1;
      wait_tick(n);
      checks++; if (n != 4) begin errors++; $display("FAIL res_tick: got %0d edges want 4", n); end
      checks++; if (q !== 8'h86 || serial_out !== 1'b1) begin errors++; $display("FAIL res_hold: got q=%h so=%b want 86/1", q, serial_out); end
   endtask

   task automatic test_reset_mid_op();
      int ticks;
      do_reset(1'b1, 1'b1, 3'b001, 8'hFF, 1'b0);
      cyc(2);
      reset_n = 1'b0;
      cyc(1);
      checks++; if (q !== 8'h00 || tick !== 1'b0) begin errors++; $display("FAIL rst_mid_count: got q=%h tick=%b want 00/0", q, tick); end
      reset_n = 1'b1;
      ticks = 0;
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         if (tick) ticks++;
      end
      checks++; if (ticks != 0 || q !== 8'h00) begin errors++; $display("FAIL rst_restart: got ticks=%0d q=%h want 0/00", ticks, q); end
      cyc(1);
      checks++; if (q !== 8'hFF || tick !== 1'b1) begin errors++; $display("FAIL rst_restart_tick: got q=%h tick=%b want ff/1", q, tick); end

      do_reset(1'b0, 1'b1, 3'b001, 8'h77, 1'b0);
      cyc(2);
      step = 1'b1;
      cyc(1);
      reset_n = 1'b0;
      cyc(1);
      checks++; if (q !== 8'h00 || tick !== 1'b0 || serial_out !== 1'b0) begin errors++; $display("FAIL rst_mid_press: got q=%h tick=%b so=%b want 00/0/0", q, tick, serial_out); end
      reset_n = 1'b1;
      cyc(2);
      checks++; if (q !== 8'h00 || tick !== 1'b0) begin errors++; $display("FAIL rst_press_early: got q=%h tick=%b want 00/0", q, tick); end
      cyc(1);
      checks++; if (q !== 8'h77 || tick !== 1'b1) begin errors++; $display("FAIL rst_press_advance: got q=%h tick=%b want 77/1", q, tick); end
      ticks = 0;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         if (tick) ticks++;
      end
      checks++; if (ticks != 0) begin errors++; $display("FAIL rst_press_single: got %0d extra ticks want 0", ticks); end
      step = 1'b0;
   endtask

   initial begin
      cyc(1);
      test_reset();
      test_auto_load_shift();
      test_manual_step();
      test_rotate();
      test_enable_reserved();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift_register_stepper.md
# shift_register_stepper

Parametrised multi-mode register: the successor to the single-bit D-flip-flop exercises. A WIDTH-bit register performs hold, load, shift, rotate or clear on an "advance" event. The advance comes either from an internal prescaler tick (auto mode) or from a synchronised, edge-detected push-button step (manual mode). Everything runs on the one board clock; no derived or gated clocks.

## Interface
Parameters:
- WIDTH, 8, register width (>= 2)
- DIVIDE, 50_000_000, clock cycles per auto tick (>= 1); prescaler width is clog2(DIVIDE), minimum 1

Ports:
- clock  in  1  board clock; all state changes on its rising edge
- reset_n  in  1  synchronous, active-low reset
- enable  in  1  1 = advances allowed; 0 = advances discarded
- auto  in  1  1 = advance on prescaler tick; 0 = advance on step pulse
- step  in  1  raw button level, active-high (already inverted at top level), asynchronous
- mode  in  3  operation applied on advance (see Operation)
- d  in  WIDTH  parallel load data
- serial_in  in  1  bit shifted in on shl/shr
- q  out  WIDTH  register contents
- serial_out  out  1  bit most recently shifted/rotated out
- tick  out  1  one-cycle pulse marking each performed advance

## Operation
- Mode encoding:
  - 000 hold
  - 001 load: q <= d
  - 010 shl: q <= {q[W-2:0], serial_in}
  - 011 shr: q <= {serial_in, q[W-1:1]}
  - 100 rotl: q <= {q[W-2:0], q[W-1]}
  - 101 rotr: q <= {q[0], q[W-1:1]}
  - 110 clear: q <= 0
  - 111 hold (reserved)
- serial_out on an advance:
  - shl and rotl: takes old q[W-1]
  - shr and rotr: takes old q[0]
  - all other modes: unchanged
- Step path:
  - Two-flop synchroniser, then a history flop.
  - step_pulse = sync2 & ~hist: exactly one cycle per rising step edge, regardless of press length.
- Prescaler:
  - When auto=1, the counter counts 0..DIVIDE-1 and wraps.
  - pre_tick = (counter == DIVIDE-1).
  - When auto=0, the counter is forced to 0.
  - The prescaler runs independently of enable.
- advance = enable & (auto ? pre_tick : step_pulse).
- mode, d and serial_in are sampled only at the advance edge.
- Pulses that occur while enable=0 are dropped, not queued.
- In auto mode, step pulses are ignored. In manual mode, prescaler ticks cannot occur.
- Reset (reset_n=0 at a rising edge):
  - q=0, serial_out=0, tick=0, counter=0, sync1/sync2/hist=0.
  - This overrides any coincident advance.
  - A step held high through reset release yields one step pulse after release. This is required and must be tested as such.

## Timing
- Step latency:
  - step first sampled high at edge N;
  - step_pulse is high during the cycle after edge N+1;
  - q, serial_out and tick update at edge N+2.
- Auto latency:
  - After reset release (first edge with reset_n=1 = edge 0, counter 0 -> 1), q updates at edge DIVIDE-1.
  - Thereafter q updates every DIVIDE edges.
  - DIVIDE=1: advance every cycle while enable=1.
- tick is registered. It is high for exactly one cycle after each advance edge, coincident with the new q value.
- auto changing 1->0: counter is 0 after the next edge. auto changing 0->1: counting starts from 0, so the first tick comes DIVIDE edges later.
- mode change: takes effect only at the next advance edge. No partial operations.
- reset_n low mid-count or mid-press:
  - all state cleared at that edge;
  - the prescaler restarts from 0 after release;
  - no tick is emitted at the reset edge.

## Test plan
- Reset: drive random values on all inputs, hold reset_n=0 for 3 cycles -> q=0x00, serial_out=0, tick=0. With auto=1, enable=1, mode=001 and DIVIDE=4, the first tick comes 3 edges after release.
- Auto load and shift (WIDTH=8, DIVIDE=4):
  - load d=0xA5, then mode=010 with serial_in=1;
  - q sequence 0xA5 -> 0x4B -> 0x97, one step every 4 cycles;
  - serial_out 1 then 0;
  - tick pulses exactly 4 cycles apart.
- Manual step edge detection (auto=0, mode=011, q=0x80, serial_in=0):
  - hold step high for 20 cycles -> exactly one advance, q=0x40, tick asserted for exactly one cycle;
  - q updates at edge N+2;
  - release and press again -> q=0x20.
- Rotate wrap-around:
  - q=0x81, rotl -> 0x03 with serial_out=1;
  - then rotr twice -> 0x81 -> 0xC0, serial_out 1 then 1.
- Enable and reserved mode:
  - enable=0 across 3 auto ticks -> q unchanged, tick stays 0;
  - re-enable mid-count -> next advance at the next counter wrap, not immediately;
  - mode=111 -> q and serial_out unchanged, tick still pulses.
- Reset mid-operation:
  - assert reset_n=0 at counter=2 and again one cycle after a step rising edge -> no advance occurs, all state 0;
  - with step still held at release, one advance occurs 3 edges later.
